fpnew_slice_req_arbiter: RTL and testbench

- Shares one opgroup format slice (one FPU datapath slice per opgroup/format) between NumReq independent requesters, e.g. two issue ports.
- Round-robin arbitration on the request side.
- An in-order ID FIFO routes each slice result back to the requester that issued it.
- Sits between the requesters and the slice; passes flush through to the slice.

---
 rtl/fpnew_slice_req_arbiter_pkg.sv | 69 ++++++
 rtl/fpnew_slice_req_arbiter_id_fifo.sv | 53 +++++
 rtl/fpnew_slice_req_arbiter.sv | 96 +++++++++
 tb/tb_fpnew_slice_req_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fpnew_slice_req_arbiter_pkg.sv
// fpnew_slice_req_arbiter_pkg: shared slice request/response types and round-robin helper
package fpnew_slice_req_arbiter_pkg;

    localparam int unsigned WIDTH        = 32;
    localparam int unsigned NUM_OPERANDS = 3;
    localparam int unsigned NUM_LANES    = 1;
    localparam int unsigned TAG_WIDTH    = 4;
    localparam int unsigned MAX_REQ      = 8;
    localparam int unsigned RR_W         = $clog2(MAX_REQ);

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef struct packed {
        logic [NUM_OPERANDS-1:0][WIDTH-1:0] operands;
        logic [NUM_OPERANDS-1:0]            is_boxed;
        roundmode_e                         rnd_mode;
        operation_e                         op;
        logic                               op_mod;
        logic                               vectorial_op;
        logic [NUM_LANES-1:0]               simd_mask;
        logic [TAG_WIDTH-1:0]               tag;
    } slice_req_t;

    typedef struct packed {
        logic [WIDTH-1:0]     result;
        status_t              status;
        logic                 extension_bit;
        logic [TAG_WIDTH-1:0] tag;
    } slice_rsp_t;

    // First set bit of mask at or above ptr, wrapping at n; returns ptr if mask is empty.
    function automatic logic [RR_W-1:0] rr_next(input logic [MAX_REQ-1:0] mask,
                                                 input logic [RR_W-1:0] ptr,
                                                 input int n);
        logic found;
        int   j;
        rr_next = ptr;
        found   = 1'b0;
        for (int i = 0; i < int'(MAX_REQ); i++) begin
            j = int'(ptr) + i;
            if (j >= n) j -= n;
            if (i < n && !found && mask[j]) begin
                found   = 1'b1;
                rr_next = RR_W'(j);
            end
        end
    endfunction

endpackage

// File: rtl/fpnew_slice_req_arbiter_id_fifo.sv
// fpnew_slice_id_fifo: in-order requester-id FIFO tracking operations inside the slice
module fpnew_slice_id_fifo #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataWidth = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [DataWidth-1:0] head_o
);

    localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0]      rd_q, wr_q;
    logic [CntW-1:0]      cnt_q;
    logic [DataWidth-1:0] mem_q [Depth];
    logic                 do_push, do_pop;

    assign full_o  = cnt_q == CntW'(Depth);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Pointer and occupancy bookkeeping; flush drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
            if (do_pop) rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Id storage; contents are only meaningful between push and pop, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/fpnew_slice_req_arbiter.sv
// fpnew_slice_req_arbiter: round-robin sharing of one FPU slice between requesters with in-order result routing
module fpnew_slice_req_arbiter
    import fpnew_slice_req_arbiter_pkg::*;
#(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned Width       = 32,
    parameter int unsigned NumOperands = 3,
    parameter int unsigned MaxInflight = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  slice_req_t [NumReq-1:0] req_i,
    output logic [NumReq-1:0]       rsp_valid_o,
    input  logic [NumReq-1:0]       rsp_ready_i,
    output slice_rsp_t              rsp_o,
    output slice_req_t              slc_req_o,
    output logic                    slc_valid_o,
    input  logic                    slc_ready_i,
    input  slice_rsp_t              slc_rsp_i,
    input  logic                    slc_valid_i,
    output logic                    slc_ready_o,
    input  logic                    flush_i,
    output logic                    slc_flush_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int unsigned IdWidth = NumReq > 1 ? $clog2(NumReq) : 1;

    if (Width != WIDTH || NumOperands != NUM_OPERANDS || NumReq < 2 || NumReq > MAX_REQ) begin : g_param_check
        $error("fpnew_slice_req_arbiter: parameters do not match the slice types in the package");
    end

    logic [IdWidth-1:0] rr_ptr_q, locked_id_q, grant, head;
    logic               lock_q, err_q;
    logic               fifo_full, fifo_empty;
    logic               issue_en, handshake, rsp_en, pop;

    // A full FIFO blocks issue even when a pop is happening: no push/pop bypass.
    assign issue_en    = rst_ni && !fifo_full && !flush_i;
    assign grant       = lock_q ? locked_id_q
                                : IdWidth'(rr_next(MAX_REQ'(req_valid_i), RR_W'(rr_ptr_q), int'(NumReq)));
    assign slc_valid_o = issue_en && req_valid_i[grant];
    assign slc_req_o   = req_i[grant];
    assign handshake   = slc_valid_o && slc_ready_i;

    // Results go back to whichever requester sits at the FIFO head; nothing is forwarded during flush.
    assign rsp_en      = rst_ni && !fifo_empty && !flush_i;
    assign slc_ready_o = rsp_en && rsp_ready_i[head];
    assign pop         = slc_valid_i && slc_ready_o;
    assign rsp_o       = slc_rsp_i;
    assign slc_flush_o = flush_i;
    assign busy_o      = !fifo_empty || slc_valid_o;
    assign err_o       = err_q;

    // One-hot steering of accept and result-valid to the granted and head requesters.
    always_comb begin
        req_ready_o       = '0;
        rsp_valid_o       = '0;
        req_ready_o[grant] = handshake;
        rsp_valid_o[head]  = slc_valid_i && rsp_en;
    end

    // Round-robin pointer, stall lock for request stability, and sticky orphan-response error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            locked_id_q <= '0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            lock_q <= slc_valid_o && !slc_ready_i;
            if (slc_valid_o && !slc_ready_i) locked_id_q <= grant;
            if (handshake) rr_ptr_q <= (grant == IdWidth'(NumReq - 1)) ? '0 : grant + 1'b1;
            if (slc_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    fpnew_slice_id_fifo #(
        .Depth     (MaxInflight),
        .DataWidth (IdWidth)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (handshake),
        .data_i  (grant),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

endmodule

// File: tb/tb_fpnew_slice_req_arbiter.sv
// tb_fpnew_slice_req_arbiter: table-driven directed check of arbitration, locking, FIFO routing, flush and error
module tb_fpnew_slice_req_arbiter;
    import fpnew_slice_req_arbiter_pkg::*;

    typedef struct packed {
        logic [1:0] rv;
        logic       sr;
        logic       sv;
        logic [1:0] rr;
        logic       fl;
        logic [1:0] e_rdy;
        logic       e_sv;
        logic       e_g;
        logic [1:0] e_rv;
        logic       e_sro;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    slice_req_t [1:0] req;
    slice_rsp_t       rsp, slc_rsp;
    slice_req_t       slc_req;
    logic             slc_valid_o, slc_ready_i, slc_valid_i, slc_ready_o;
    logic             flush, slc_flush, busy, err;
    int               ntot = 0;
    int               npass = 0;
    vec_t             vt [31];

    always #5 clk = ~clk;

    fpnew_slice_req_arbiter #(
        .NumReq(2), .Width(32), .NumOperands(3), .MaxInflight(4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_i       (req),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_o       (rsp),
        .slc_req_o   (slc_req),
        .slc_valid_o (slc_valid_o),
        .slc_ready_i (slc_ready_i),
        .slc_rsp_i   (slc_rsp),
        .slc_valid_i (slc_valid_i),
        .slc_ready_o (slc_ready_o),
        .flush_i     (flush),
        .slc_flush_o (slc_flush),
        .busy_o      (busy),
        .err_o       (err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k]              = '0;
            req[k].operands[0]  = 32'hA000_0000 | 32'(k);
            req[k].operands[2]  = 32'hC000_0000 | 32'(k);
            req[k].op           = ADD;
            req[k].rnd_mode     = RNE;
            req[k].tag          = 4'(k + 5);
        end
        slc_rsp = '0;
        //          rv     sr    sv    rr     fl   | rdy    sv    g     rv     sro   busy  err
        vt[0]  = '{2'b01,1'b1,1'b0,2'b00,1'b0, 2'b01,1'b1,1'b0,2'b00,1'b0,1'b1,1'b0};
        vt[1]  = '{2'b01,1'b1,1'b0,2'b00,1'b0, 2'b01,1'b1,1'b0,2'b00,1'b0,1'b1,1'b0};
        vt[2]  = '{2'b00,1'b1,1'b1,2'b01,1'b0, 2'b00,1'b0,1'b0,2'b01,1'b1,1'b1,1'b0};
        vt[3]  = '{2'b00,1'b1,1'b1,2'b01,1'b0, 2'b00,1'b0,1'b0,2'b01,1'b1,1'b1,1'b0};
        vt[4]  = '{2'b00,1'b0,1'b0,2'b00,1'b0, 2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0};
        vt[5]  = '{2'b11,1'b1,1'b0,2'b00,1'b0, 2'b10,1'b1,1'b1,2'b00,1'b0,1'b1,1'b0};
        vt[6]  = '{2'b11,1'b1,1'b0,2'b00,1'b0, 2'b01,1'b1,1'b0,2'b00,1'b0,1'b1,1'b0};
        vt[7]  = '{2'b11,1'b1,1'b1,2'b11,1'b0, 2'b10,1'b1,1'b1,2'b10,1'b1,1'b1,1'b0};
        vt[8]  = '{2'b11,1'b1,1'b1,2'b11,1'b0, 2'b01,1'b1,1'b0,2'b01,1'b1,1'b1,1'b0};
        vt[9]  = '{2'b00,1'b1,1'b1,2'b11,1'b0, 2'b00,1'b0,1'b0,2'b10,1'b1,1'b1,1'b0};
        vt[10] = '{2'b00,1'b1,1'b1,2'b11,1'b0, 2'b00,1'b0,1'b0,2'b01,1'b1,1'b1,1'b0};
        vt[11] = '{2'b10,1'b1,1'b0,2'b00,1'b0, 2'b10,1'b1,1'b1,2'b00,1'b0,1'b1,1'b0};
        vt[12] = '{2'b10,1'b0,1'b0,2'b00,1'b0, 2'b00,1'b1,1'b1,2'b00,1'b0,1'b1,1'b0};
        vt[13] = '{2'b11,1'b0,1'b0,2'b00,1'b0, 2'b00,1'b1,1'b1,2'b00,1'b0,1'b1,1'b0};
        vt[14] = '{2'b11,1'b0,1'b0,2'b00,1'b0, 2'b00,1'b1,1'b1,2'b00,1'b0,1'b1,1'b0};
        vt[15] = '{2'b11,1'b1,1'b0,2'b00,1'b0, 2'b10,1'b1,1'b1,2'b00,1'b0,1'b1,1'b0};
        vt[16] = '{2'b11,1'b1,1'b0,2'b00,1'b0, 2'b01,1'b1,1'b0,2'b00,1'b0,1'b1,1'b0};
        vt[17] = '{2'b11,1'b1,1'b0,2'b00,1'b0, 2'b10,1'b1,1'b1,2'b00,1'b0,1'b1,1'b0};
        vt[18] = '{2'b11,1'b1,1'b0,2'b00,1'b0, 2'b00,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0};
        vt[19] = '{2'b11,1'b1,1'b1,2'b11,1'b0, 2'b00,1'b0,1'b0,2'b10,1'b1,1'b1,1'b0};
        vt[20] = '{2'b11,1'b1,1'b0,2'b00,1'b0, 2'b01,1'b1,1'b0,2'b00,1'b0,1'b1,1'b0};
        vt[21] = '{2'b00,1'b0,1'b1,2'b00,1'b0, 2'b00,1'b0,1'b0,2'b10,1'b0,1'b1,1'b0};
        vt[22] = '{2'b00,1'b0,1'b1,2'b01,1'b0, 2'b00,1'b0,1'b0,2'b10,1'b0,1'b1,1'b0};
        vt[23] = '{2'b00,1'b0,1'b1,2'b10,1'b0, 2'b00,1'b0,1'b0,2'b10,1'b1,1'b1,1'b0};
        vt[24] = '{2'b00,1'b0,1'b1,2'b11,1'b0, 2'b00,1'b0,1'b0,2'b01,1'b1,1'b1,1'b0};
        vt[25] = '{2'b01,1'b1,1'b0,2'b00,1'b0, 2'b01,1'b1,1'b0,2'b00,1'b0,1'b1,1'b0};
        vt[26] = '{2'b11,1'b1,1'b1,2'b11,1'b1, 2'b00,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0};
        vt[27] = '{2'b00,1'b0,1'b0,2'b00,1'b0, 2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0};
        vt[28] = '{2'b00,1'b0,1'b1,2'b11,1'b0, 2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0};
        vt[29] = '{2'b00,1'b0,1'b0,2'b00,1'b0, 2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1};
        vt[30] = '{2'b11,1'b1,1'b0,2'b00,1'b0, 2'b10,1'b1,1'b1,2'b00,1'b0,1'b1,1'b1};

        req_valid   = 2'b11;
        slc_ready_i = 1'b1;
        slc_valid_i = 1'b1;
        rsp_ready   = 2'b11;
        flush       = 1'b0;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_slc_valid", 64'(slc_valid_o), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_slc_ready", 64'(slc_ready_o), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        req_valid   = 2'b00;
        slc_ready_i = 1'b0;
        slc_valid_i = 1'b0;
        rsp_ready   = 2'b00;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 31; i++) begin
            req_valid      = vt[i].rv;
            slc_ready_i    = vt[i].sr;
            slc_valid_i    = vt[i].sv;
            rsp_ready      = vt[i].rr;
            flush          = vt[i].fl;
            slc_rsp.result = $urandom;
            slc_rsp.tag    = 4'($urandom_range(0, 15));
            #1;
            chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(vt[i].e_rdy));
            chk($sformatf("v%0d_slc_valid", i), 64'(slc_valid_o), 64'(vt[i].e_sv));
            if (vt[i].e_sv)
                chk($sformatf("v%0d_slc_req", i), {28'h0, slc_req.tag, slc_req.operands[0]},
                    {28'h0, req[vt[i].e_g].tag, req[vt[i].e_g].operands[0]});
            chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(vt[i].e_rv));
            chk($sformatf("v%0d_slc_ready", i), 64'(slc_ready_o), 64'(vt[i].e_sro));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vt[i].e_err));
            chk($sformatf("v%0d_flush_fwd", i), 64'(slc_flush), 64'(vt[i].fl));
            chk($sformatf("v%0d_rsp_data", i), {28'h0, rsp.tag, rsp.result}, {28'h0, slc_rsp.tag, slc_rsp.result});
            @(negedge clk);
        end

        rst_ni = 1'b0;
        #1;
        chk("rerst_err", 64'(err), 64'h0);
        chk("rerst_slc_valid", 64'(slc_valid_o), 64'h0);
        chk("rerst_busy", 64'(busy), 64'h0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
